// File: rtl/rc_servo_frame_scheduler_if.sv
// Position request and servo pin bundle for rc_servo_frame_scheduler.
// The scheduler uses the slave modport; the position source uses master.
interface rc_servo_frame_scheduler_if #(
    parameter int POS_W = 10
);
    logic             ena;
    logic [POS_W-1:0] pos_x_i;
    logic             pos_x_valid_i;
    logic             pos_x_ready_o;
    logic [POS_W-1:0] pos_y_i;
    logic             pos_y_valid_i;
    logic             pos_y_ready_o;
    logic             pwm_x_o;
    logic             pwm_y_o;
    logic             frame_start_o;

    modport slave (
        input  ena, pos_x_i, pos_x_valid_i, pos_y_i, pos_y_valid_i,
        output pos_x_ready_o, pos_y_ready_o, pwm_x_o, pwm_y_o, frame_start_o
    );

    modport master (
        output ena, pos_x_i, pos_x_valid_i, pos_y_i, pos_y_valid_i,
        input  pos_x_ready_o, pos_y_ready_o, pwm_x_o, pwm_y_o, frame_start_o
    );
endinterface

// File: rtl/rc_servo_frame_scheduler.sv
// Two-channel RC-servo frame scheduler: X pulse, gap, Y pulse, rest, per frame.
// Define SERVO_SLEW_LIMIT_EN to limit the per-frame width change to SLEW_US.
module rc_servo_frame_scheduler #(
    parameter int TICK_DIV = 10,
    parameter int FRAME_US = 20000,
    parameter int MIN_US   = 1000,
    parameter int MAX_US   = 2000,
    parameter int GAP_US   = 10,
    parameter int POS_W    = 10,
    parameter int SLEW_US  = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    rc_servo_frame_scheduler_if.slave      bus
);

    localparam int SPAN_US   = MAX_US - MIN_US;
    localparam int CENTRE_US = MIN_US + SPAN_US / 2;
    localparam int US_W      = $clog2(FRAME_US + 1);
    localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef logic [US_W-1:0] us_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE_X,
        ST_GAP,
        ST_PULSE_Y,
        ST_REST
    } state_t;

    state_t            state_q;
    logic [TICK_W-1:0] tick_q;
    us_t               us_q;
    logic              pwm_x_q;
    logic              pwm_y_q;
    logic              frame_start_q;

    logic [1:0][POS_W-1:0] pos_w;
    logic [1:0]            valid_w;
    logic [1:0]            ready_w;
    logic [1:0][US_W-1:0]  active_w;

    logic tick_wrap;
    logic frame_end;
    logic frame_go;
    us_t  us_inc;
    us_t  y_start;
    us_t  y_end;

    assign pos_w[0]   = bus.pos_x_i;
    assign pos_w[1]   = bus.pos_y_i;
    assign valid_w[0] = bus.pos_x_valid_i;
    assign valid_w[1] = bus.pos_y_valid_i;

    assign bus.pos_x_ready_o = ready_w[0];
    assign bus.pos_y_ready_o = ready_w[1];
    assign bus.pwm_x_o       = pwm_x_q;
    assign bus.pwm_y_o       = pwm_y_q;
    assign bus.frame_start_o = frame_start_q;

    // A new frame begins on the first enabled clock or when the last tick of
    // the last microsecond of the current frame completes.
    assign tick_wrap = (tick_q == TICK_W'(TICK_DIV - 1));
    assign frame_end = tick_wrap && (us_q == US_W'(FRAME_US - 1));
    assign frame_go  = bus.ena && ((state_q == ST_IDLE) || frame_end);
    assign us_inc    = us_q + US_W'(1);
    assign y_start   = active_w[0] + US_W'(GAP_US);
    assign y_end     = y_start + active_w[1];

    // Elaborates only for an unusable parameter set; it carries no logic.
    if ((TICK_DIV < 1) || (GAP_US < 1) || (SLEW_US < 0) ||
        (FRAME_US <= 2 * MAX_US + GAP_US)) begin : g_illegal_cfg
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_chan
        us_t  shadow_q;
        us_t  target_q;
        us_t  active_q;
        logic pending_q;
        logic xfer;
        us_t  code_us;
        us_t  target_eff;
        us_t  active_nxt;

        assign xfer       = valid_w[gi] && !pending_q;
        assign code_us    = (32'(pos_w[gi]) > 32'(SPAN_US)) ? US_W'(MAX_US)
                                                            : US_W'(MIN_US) + US_W'(pos_w[gi]);
        assign target_eff = pending_q ? shadow_q : target_q;

`ifdef SERVO_SLEW_LIMIT_EN
        always_comb begin
            active_nxt = target_eff;
            if (target_eff > active_q + US_W'(SLEW_US)) begin
                active_nxt = active_q + US_W'(SLEW_US);
            end else if (target_eff + US_W'(SLEW_US) < active_q) begin
                active_nxt = active_q - US_W'(SLEW_US);
            end
        end
`else
        assign active_nxt = target_eff;
`endif

        // A transfer coinciding with a frame start is kept pending for the
        // following frame; the frame start only consumes an older request.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q  <= US_W'(CENTRE_US);
                target_q  <= US_W'(CENTRE_US);
                active_q  <= US_W'(CENTRE_US);
                pending_q <= 1'b0;
            end else begin
                if (frame_go) begin
                    target_q <= target_eff;
                    active_q <= active_nxt;
                end
                if (xfer) begin
                    shadow_q  <= code_us;
                    pending_q <= 1'b1;
                end else if (frame_go) begin
                    pending_q <= 1'b0;
                end
            end
        end

        assign ready_w[gi]  = !pending_q;
        assign active_w[gi] = active_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            tick_q        <= '0;
            us_q          <= '0;
            pwm_x_q       <= 1'b0;
            pwm_y_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (!bus.ena) begin
            state_q       <= ST_IDLE;
            tick_q        <= '0;
            us_q          <= '0;
            pwm_x_q       <= 1'b0;
            pwm_y_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (frame_go) begin
            state_q       <= ST_PULSE_X;
            tick_q        <= '0;
            us_q          <= '0;
            pwm_x_q       <= 1'b1;
            pwm_y_q       <= 1'b0;
            frame_start_q <= 1'b1;
        end else begin
            frame_start_q <= 1'b0;
            tick_q        <= tick_wrap ? '0 : tick_q + TICK_W'(1);
            if (tick_wrap) begin
                us_q <= us_inc;
                // Phase edges fall on microsecond boundaries of the frame.
                case (state_q)
                    ST_PULSE_X: begin
                        if (us_inc == active_w[0]) begin
                            state_q <= ST_GAP;
                            pwm_x_q <= 1'b0;
                        end
                    end
                    ST_GAP: begin
                        if (us_inc == y_start) begin
                            state_q <= ST_PULSE_Y;
                            pwm_y_q <= 1'b1;
                        end
                    end
                    ST_PULSE_Y: begin
                        if (us_inc == y_end) begin
                            state_q <= ST_REST;
                            pwm_y_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
